// File: rtl/fdc_pkg.sv
// Shared definitions for the 765-class FDC: FSM encoding, interrupt codes,
// status bit positions and sector/drive sizing helpers.
package fdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DRAIN,
    S_COLLECT,
    S_COMMIT,
    S_NEXT,
    S_DONE
  } fdc_state_e;

  localparam logic [1:0] IC_NORMAL   = 2'b00;
  localparam logic [1:0] IC_ABNORMAL = 2'b01;

  localparam int ST1_EN = 7;
  localparam int ST1_DE = 5;
  localparam int ST1_OR = 4;
  localparam int ST1_ND = 2;

  function automatic int drv_w(input int num_drives);
    return (num_drives > 1) ? $clog2(num_drives) : 1;
  endfunction

  function automatic int unsigned sector_bytes(input logic [2:0] n_code);
    return 32'd128 << n_code;
  endfunction

  function automatic logic [2:0] clamp_n(input logic [2:0] n_code, input int max_n);
    if (int'(n_code) > max_n) return 3'(max_n);
    return n_code;
  endfunction

endpackage

// File: rtl/fdc_sector_buf.sv
// Single sector buffer: one write port, one read port, registered read data.
module fdc_sector_buf #(
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array and its read register carry no reset so they map onto block RAM;
  // every byte is written before the engine reads it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fdc_sector_engine.sv
// Multi-sector READ DATA / WRITE DATA execution engine between the CPU data register
// and the host sector server. Define OVERRUN_DETECT_EN to enable CPU overrun detection.
module fdc_sector_engine
  import fdc_pkg::*;
#(
  parameter int NUM_DRIVES = 2,
  parameter int MAX_N      = 2,
  parameter int OVR_CYCLES = 256,
  parameter int DRV_W      = drv_w(NUM_DRIVES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wr_cmd,
  input  logic [DRV_W-1:0] drive,
  input  logic [7:0]       cyl,
  input  logic [7:0]       rec,
  input  logic [7:0]       eot,
  input  logic             head,
  input  logic [2:0]       n,
  input  logic             tc,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_din,
  output logic [7:0]       cpu_dout,
  output logic             rqm,
  output logic             dio,
  output logic             busy,
  output logic             host_req,
  output logic             host_wr,
  output logic [DRV_W-1:0] host_drive,
  output logic [7:0]       host_cyl,
  output logic             host_head,
  output logic [7:0]       host_rec,
  output logic [2:0]       host_n,
  input  logic [7:0]       host_din,
  input  logic             host_din_vld,
  output logic [7:0]       host_dout,
  input  logic             host_dout_rd,
  input  logic             host_ack,
  input  logic             host_err,
  output logic             done,
  output logic [7:0]       st0,
  output logic [7:0]       st1,
  output logic [7:0]       res_c,
  output logic [7:0]       res_r,
  output logic             res_h,
  output logic [2:0]       res_n
);

  localparam int AW = 7 + MAX_N;
  localparam int CW = AW + 1;

  fdc_state_e       state_q, state_d;
  logic             wr_cmd_q, wr_cmd_d, head_q, head_d, tc_q, tc_d;
  logic [DRV_W-1:0] drive_q, drive_d;
  logic [7:0]       cyl_q, cyl_d, rec_q, rec_d, eot_q, eot_d;
  logic [2:0]       n_q, n_d;
  logic [CW-1:0]    wp_q, wp_d, rp_q, rp_d, size;
  logic [7:0]       cpu_dout_q, cpu_dout_d, st0_q, st0_d, st1_q, st1_d, res_r_q, res_r_d;
  logic             rqm_q, rqm_d, dio_q, dio_d, busy_q, busy_d, done_q, done_d;
  logic             mem_we, mem_re, pop, go_done, ovr_hit;
  logic [7:0]       mem_wd, mem_rd, fin_st1, fin_r;
  logic [1:0]       fin_ic;

  assign size = CW'(sector_bytes(n_q));
  // The read port always pre-fetches buf[rp], giving show-ahead data for both consumers.
  assign mem_re = (state_d == S_DRAIN) || (state_d == S_COMMIT);

  fdc_sector_buf #(.DEPTH(128 << MAX_N)) u_buf (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wp_q[AW-1:0]),
    .wr_data (mem_wd),
    .rd_en   (mem_re),
    .rd_addr (rp_d[AW-1:0]),
    .rd_data (mem_rd)
  );

  // NOTE: all next-state values get a default before the case so no path leaves one unassigned.
  always_comb begin
    state_d = state_q;  wr_cmd_d = wr_cmd_q; drive_d = drive_q; cyl_d = cyl_q;
    head_d  = head_q;   rec_d    = rec_q;    eot_d   = eot_q;   n_d   = n_q;
    tc_d    = tc_q | tc;
    wp_d    = wp_q;     rp_d     = rp_q;
    mem_we  = 1'b0;     mem_wd   = cpu_din;  pop     = 1'b0;
    go_done = 1'b0;     fin_ic   = IC_NORMAL; fin_st1 = '0;     fin_r = rec_q;
    st0_d   = st0_q;    st1_d    = st1_q;    res_r_d = res_r_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          wr_cmd_d = wr_cmd; drive_d = drive; cyl_d = cyl; head_d = head;
          rec_d    = rec;    eot_d   = eot;   n_d   = clamp_n(n, MAX_N);
          tc_d     = 1'b0;   wp_d    = '0;    rp_d  = '0;
          state_d  = wr_cmd ? S_COLLECT : S_REQ;
        end
      end
      S_REQ, S_FILL: begin
        state_d = S_FILL;
        if (host_din_vld && (wp_q < size)) begin
          mem_we = 1'b1; mem_wd = host_din; wp_d = wp_q + 1'b1;
        end
        if (host_ack) begin
          if (host_err) begin
            go_done = 1'b1; fin_ic = IC_ABNORMAL; fin_st1[ST1_ND] = 1'b1;
          end else if (wp_d < size) begin
            go_done = 1'b1; fin_ic = IC_ABNORMAL; fin_st1[ST1_DE] = 1'b1;
          end else begin
            state_d = S_DRAIN; rp_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (ovr_hit) begin
          go_done = 1'b1; fin_ic = IC_ABNORMAL; fin_st1[ST1_OR] = 1'b1;
        end else if (tc) begin
          go_done = 1'b1; fin_r = rec_q + 8'd1;
        end else if (rp_q < wp_q) begin
          if (cpu_rd) begin
            pop = 1'b1; rp_d = rp_q + 1'b1;
          end
        end else begin
          state_d = S_NEXT;
        end
      end
      S_COLLECT: begin
        if (ovr_hit) begin
          go_done = 1'b1; fin_ic = IC_ABNORMAL; fin_st1[ST1_OR] = 1'b1;
        end else begin
          // After tc the rest of the sector is padded with zeros, one byte per clock.
          if (tc_q) begin
            mem_we = 1'b1; mem_wd = 8'h00; wp_d = wp_q + 1'b1;
          end else if (cpu_wr) begin
            mem_we = 1'b1; wp_d = wp_q + 1'b1;
          end
          if (wp_d == size) begin
            state_d = S_COMMIT; rp_d = '0;
          end
        end
      end
      S_COMMIT: begin
        if (host_dout_rd && (rp_q < size)) rp_d = rp_q + 1'b1;
        if (host_ack) begin
          if (host_err) begin
            go_done = 1'b1; fin_ic = IC_ABNORMAL; fin_st1[ST1_ND] = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (tc_d) begin
          go_done = 1'b1; fin_r = rec_q + 8'd1;
        end else if (rec_q == eot_q) begin
          go_done = 1'b1; fin_ic = IC_ABNORMAL; fin_st1[ST1_EN] = 1'b1; fin_r = rec_q + 8'd1;
        end else begin
          rec_d   = rec_q + 8'd1; wp_d = '0; rp_d = '0;
          state_d = wr_cmd_q ? S_COLLECT : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_done) begin
      state_d = S_DONE;
      st0_d   = {fin_ic, 3'b000, head_q, 2'(drive_q)};
      st1_d   = fin_st1;
      res_r_d = fin_r;
    end

    cpu_dout_d = pop ? mem_rd : cpu_dout_q;
    rqm_d      = ((state_d == S_DRAIN) && (rp_d < wp_d)) || ((state_d == S_COLLECT) && !tc_d);
    dio_d      = (state_d == S_DRAIN) && (rp_d < wp_d);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = go_done;
  end

`ifdef OVERRUN_DETECT_EN
  localparam int OW = $clog2(OVR_CYCLES + 1);
  logic [OW-1:0] ovr_q, ovr_d;
  logic          serviced;

  assign serviced = pop || ((state_q == S_COLLECT) && mem_we && !tc_q);
  assign ovr_hit  = (ovr_q == OW'(OVR_CYCLES));

  always_comb begin
    ovr_d = '0;
    if (rqm_q && !serviced && !ovr_hit && ((state_q == S_DRAIN) || (state_q == S_COLLECT)))
      ovr_d = ovr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovr_q <= '0;
    else        ovr_q <= ovr_d;
  end
`else
  logic [31:0] ovr_cycles_unused;
  assign ovr_cycles_unused = 32'(OVR_CYCLES);
  assign ovr_hit           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE; wr_cmd_q <= 1'b0; drive_q <= '0;    cyl_q   <= '0;
      head_q   <= 1'b0;   rec_q    <= '0;   eot_q   <= '0;    n_q     <= '0;
      tc_q     <= 1'b0;   wp_q     <= '0;   rp_q    <= '0;    cpu_dout_q <= '0;
      st0_q    <= '0;     st1_q    <= '0;   res_r_q <= '0;
      rqm_q    <= 1'b0;   dio_q    <= 1'b0; busy_q  <= 1'b0;  done_q  <= 1'b0;
    end else begin
      state_q  <= state_d; wr_cmd_q <= wr_cmd_d; drive_q <= drive_d; cyl_q   <= cyl_d;
      head_q   <= head_d;  rec_q    <= rec_d;    eot_q   <= eot_d;   n_q     <= n_d;
      tc_q     <= tc_d;    wp_q     <= wp_d;     rp_q    <= rp_d;    cpu_dout_q <= cpu_dout_d;
      st0_q    <= st0_d;   st1_q    <= st1_d;    res_r_q <= res_r_d;
      rqm_q    <= rqm_d;   dio_q    <= dio_d;    busy_q  <= busy_d;  done_q  <= done_d;
    end
  end

  assign cpu_dout   = cpu_dout_q;
  assign rqm        = rqm_q;
  assign dio        = dio_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign host_req   = (state_q == S_REQ) || (state_q == S_FILL) || (state_q == S_COMMIT);
  assign host_wr    = (state_q == S_COMMIT);
  assign host_dout  = (state_q == S_COMMIT) ? mem_rd : 8'h00;
  assign host_drive = drive_q;
  assign host_cyl   = cyl_q;
  assign host_head  = head_q;
  assign host_rec   = rec_q;
  assign host_n     = n_q;
  assign st0        = st0_q;
  assign st1        = st1_q;
  assign res_c      = cyl_q;
  assign res_h      = head_q;
  assign res_r      = res_r_q;
  assign res_n      = n_q;

endmodule

// File: tb/tb_fdc_sector_engine.sv
// Directed bench for fdc_sector_engine: multi-sector read/write, tc, errors, wrap, clamp, reset.
// Define OVERRUN_DETECT_EN to also exercise the overrun path (OVR_CYCLES=16).
module tb_fdc_sector_engine;

  localparam int DRV_W = 1;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_cmd = 1'b0;
  logic [DRV_W-1:0] drive = '0;
  logic [7:0]       cyl = '0, rec = '0, eot = '0;
  logic             head = 1'b0;
  logic [2:0]       n = '0;
  logic             tc = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]       cpu_din = '0, cpu_dout;
  logic             rqm, dio, busy, host_req, host_wr;
  logic [DRV_W-1:0] host_drive;
  logic [7:0]       host_cyl, host_rec, host_dout;
  logic             host_head;
  logic [2:0]       host_n;
  logic [7:0]       host_din = '0;
  logic             host_din_vld = 1'b0, host_dout_rd = 1'b0, host_ack = 1'b0, host_err = 1'b0;
  logic             done;
  logic [7:0]       st0, st1, res_c, res_r;
  logic             res_h;
  logic [2:0]       res_n;

  int checks   = 0;
  int failures = 0;

  fdc_sector_engine #(.NUM_DRIVES(2), .MAX_N(2), .OVR_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_cmd(wr_cmd), .drive(drive),
    .cyl(cyl), .rec(rec), .eot(eot), .head(head), .n(n), .tc(tc),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .rqm(rqm), .dio(dio), .busy(busy),
    .host_req(host_req), .host_wr(host_wr), .host_drive(host_drive), .host_cyl(host_cyl),
    .host_head(host_head), .host_rec(host_rec), .host_n(host_n),
    .host_din(host_din), .host_din_vld(host_din_vld), .host_dout(host_dout),
    .host_dout_rd(host_dout_rd), .host_ack(host_ack), .host_err(host_err),
    .done(done), .st0(st0), .st1(st1), .res_c(res_c), .res_r(res_r), .res_h(res_h), .res_n(res_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rpat(input int s, input int i);
    return 8'(i * 5 + s * 17 + 3);
  endfunction

  function automatic logic [7:0] wpat(input int i);
    return 8'(i * 3 + 1) ^ 8'hA5;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic issue(input bit w, input logic [DRV_W-1:0] drv, input logic [7:0] c,
                       input logic r_first, input logic [7:0] r, input logic [7:0] e,
                       input logic [2:0] nn);
    wr_cmd = w; drive = drv; cyl = c; head = r_first; rec = r; eot = e; n = nn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!host_req && k < 1000) begin
      tick();
      k++;
    end
    check(tag, host_req, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!done && k < lim) begin
      tick();
      k++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic serve_read(input int s, input int nb, input bit err, input logic [7:0] exp_rec);
    wait_req("rd_host_req");
    check("rd_host_rec", host_rec, exp_rec);
    check("rd_host_wr", host_wr, 1'b0);
    for (int i = 0; i < nb; i++) begin
      host_din = rpat(s, i); host_din_vld = 1'b1;
      tick();
    end
    host_din_vld = 1'b0;
    host_ack = 1'b1; host_err = err;
    tick();
    host_ack = 1'b0; host_err = 1'b0;
    check("rd_host_req_drop", host_req, 1'b0);
  endtask

  task automatic cpu_read(input int s, input int nb, input string tag);
    int errs = 0;
    for (int i = 0; i < nb; i++) begin
      int k = 0;
      while (!rqm && k < 100) begin
        tick();
        k++;
      end
      if (!rqm || !dio) begin
        errs++;
        break;
      end
      cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      if (cpu_dout !== rpat(s, i)) errs++;
    end
    check(tag, errs, 0);
  endtask

  task automatic cpu_write(input int nb, input string tag);
    int errs = 0;
    for (int i = 0; i < nb; i++) begin
      int k = 0;
      while (!rqm && k < 100) begin
        tick();
        k++;
      end
      if (!rqm || dio) begin
        errs++;
        break;
      end
      cpu_din = wpat(i); cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
    end
    check(tag, errs, 0);
  endtask

  task automatic serve_commit(input int ntrue, input string tag);
    int errs = 0;
    wait_req("wr_host_req");
    check("wr_host_wr", host_wr, 1'b1);
    for (int i = 0; i < 512; i++) begin
      if (host_dout !== ((i < ntrue) ? wpat(i) : 8'h00)) errs++;
      host_dout_rd = 1'b1;
      tick();
    end
    host_dout_rd = 1'b0;
    check(tag, errs, 0);
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    check("wr_host_req_drop", host_req, 1'b0);
  endtask

  initial begin
    do_reset();
    check("rst_rqm", rqm, 1'b0);
    check("rst_dio", dio, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_host_req", host_req, 1'b0);
    check("rst_host_wr", host_wr, 1'b0);
    check("rst_st0", st0, 8'h00);
    check("rst_st1", st1, 8'h00);
    check("rst_res_r", res_r, 8'h00);
    check("rst_cpu_dout", cpu_dout, 8'h00);
    check("rst_host_dout", host_dout, 8'h00);

    // Two-sector read running into EOT.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'hC1, 8'hC2, 3'd2);
    check("rd1_busy", busy, 1'b1);
    check("rd1_host_n", host_n, 3'd2);
    serve_read(0, 512, 1'b0, 8'hC1);
    cpu_read(0, 512, "rd1_data_s0");
    serve_read(1, 512, 1'b0, 8'hC2);
    cpu_read(1, 512, "rd1_data_s1");
    wait_done("rd1_done", 20);
    check("rd1_st0", st0, 8'h40);
    check("rd1_st1", st1, 8'h80);
    check("rd1_res_r", res_r, 8'hC3);
    check("rd1_res_n", res_n, 3'd2);
    check("rd1_busy_drop", busy, 1'b0);
    tick();
    check("rd1_done_pulse", done, 1'b0);

    // Same read, terminal count after byte 700.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'hC1, 8'hC2, 3'd2);
    serve_read(0, 512, 1'b0, 8'hC1);
    cpu_read(0, 512, "rd2_data_s0");
    serve_read(1, 512, 1'b0, 8'hC2);
    cpu_read(1, 188, "rd2_data_s1");
    tc = 1'b1;
    tick();
    tc = 1'b0;
    wait_done("rd2_done", 20);
    check("rd2_st0", st0, 8'h00);
    check("rd2_st1", st1, 8'h00);
    check("rd2_res_r", res_r, 8'hC3);
    check("rd2_rqm", rqm, 1'b0);

    // Single-sector write at EOT.
    issue(1'b1, 1'b0, 8'h05, 1'b1, 8'hC1, 8'hC1, 3'd2);
    cpu_write(512, "wr1_cpu");
    serve_commit(512, "wr1_host_data");
    wait_done("wr1_done", 20);
    check("wr1_st0", st0, 8'h44);
    check("wr1_st1", st1, 8'h80);
    check("wr1_res_r", res_r, 8'hC2);
    check("wr1_res_c", res_c, 8'h05);
    check("wr1_res_h", res_h, 1'b1);

    // Write cut short by tc: zero padding then commit.
    issue(1'b1, 1'b0, 8'h00, 1'b0, 8'hC1, 8'hC4, 3'd2);
    cpu_write(100, "wr2_cpu");
    tc = 1'b1;
    tick();
    tc = 1'b0;
    check("wr2_rqm_after_tc", rqm, 1'b0);
    serve_commit(100, "wr2_host_pad");
    wait_done("wr2_done", 20);
    check("wr2_st0", st0, 8'h00);
    check("wr2_st1", st1, 8'h00);
    check("wr2_res_r", res_r, 8'hC2);

    // Sector not found on drive 1.
    issue(1'b0, 1'b1, 8'h00, 1'b0, 8'h05, 8'h09, 3'd2);
    check("nd_host_drive", host_drive, 1'b1);
    serve_read(0, 0, 1'b1, 8'h05);
    check("nd_rqm", rqm, 1'b0);
    wait_done("nd_done", 20);
    check("nd_st0", st0, 8'h41);
    check("nd_st1", st1, 8'h04);

    // Short sector from host.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h01, 3'd0);
    serve_read(0, 100, 1'b0, 8'h01);
    wait_done("de_done", 20);
    check("de_st0", st0, 8'h40);
    check("de_st1", st1, 8'h20);
    check("de_rqm", rqm, 1'b0);

    // 128-byte sector, extra host bytes dropped, R wraps past FF.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF, 3'd0);
    serve_read(2, 130, 1'b0, 8'hFF);
    cpu_read(2, 128, "wrap_data");
    check("wrap_rqm_empty", rqm, 1'b0);
    wait_done("wrap_done", 20);
    check("wrap_res_r", res_r, 8'h00);
    check("wrap_st1", st1, 8'h80);
    check("wrap_res_n", res_n, 3'd0);

    // Sector code above MAX_N is clamped.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h01, 3'd3);
    wait_req("clamp_req");
    check("clamp_host_n", host_n, 3'd2);
    serve_read(0, 0, 1'b1, 8'h01);
    wait_done("clamp_done", 20);
    check("clamp_res_n", res_n, 3'd2);

`ifdef OVERRUN_DETECT_EN
    // CPU ignores a full buffer for OVR_CYCLES clocks.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h01, 3'd0);
    serve_read(0, 128, 1'b0, 8'h01);
    check("ovr_rqm", rqm, 1'b1);
    wait_done("ovr_done", 40);
    check("ovr_st0", st0, 8'h40);
    check("ovr_st1", st1, 8'h10);
`endif

    // Reset mid-FILL aborts silently.
    issue(1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h02, 3'd2);
    wait_req("rstf_req");
    for (int i = 0; i < 10; i++) begin
      host_din = rpat(0, i); host_din_vld = 1'b1;
      tick();
    end
    host_din_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rstf_host_req", host_req, 1'b0);
    check("rstf_busy", busy, 1'b0);
    check("rstf_st1", st1, 8'h00);
    rst_n = 1'b1;
    tick();
    check("rstf_done", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
